decoder_nto1hot_seq: RTL and testbench



---
 rtl/decoder_nto1hot_seq.sv | 84 ++++++++
 tb/tb_decoder_nto1hot_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto1hot_seq.sv
// Registered N-to-one-hot decoder with level, pulse and prescaled auto-scan modes.
// Latency: 1 cycle from accepted sel to y/err. There is no backpressure; en=0 gates outputs low.
module decoder_nto1hot_seq #(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int SCAN_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] y,
  output logic               y_valid,
  output logic               err
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]  NUM_OUT_W  = (SEL_W + 1)'(NUM_OUT);
  localparam logic [1:0]      MODE_PULSE = 2'b01;
  localparam logic [1:0]      MODE_SCAN  = 2'b10;

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [NUM_OUT-1:0] y_q, y_d;
  logic               y_valid_q;
  logic               err_q, err_d;
  logic               sel_in_range;

  assign sel_in_range = {1'b0, sel} < NUM_OUT_W;

  // The prescaler is held at zero outside scan, so entering scan always starts a full dwell.
  always_comb begin
    idx_d = idx_q;
    pre_d = '0;
    y_d   = y_q;
    err_d = 1'b0;
    if (!en) begin
      y_d = '0;
    end else if (mode == MODE_SCAN) begin
      y_d = NUM_OUT'(1) << idx_q;
      if (pre_q == PRE_LAST) begin
        // Compare before incrementing so idx never overflows when NUM_OUT == 2**SEL_W.
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end else if (sel_valid) begin
      if (sel_in_range) begin
        idx_d = sel;
        y_d   = NUM_OUT'(1) << sel;
      end else begin
        y_d   = '0;
        err_d = 1'b1;
      end
    end else if (mode == MODE_PULSE) begin
      y_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      pre_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      pre_q     <= pre_d;
      y_q       <= y_d;
      y_valid_q <= |y_d;
      err_q     <= err_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_decoder_nto1hot_seq.sv
// Two decoder instances (6 outputs / dwell 3, and 8 outputs / dwell 1) share one stimulus
// stream; both are checked every cycle against an integer reference model.
module tb_decoder_nto1hot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       sel_valid;
  logic [2:0] sel;

  logic [5:0] ya;
  logic       yva, erra;
  logic [7:0] yb;
  logic       yvb, errb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_nto1hot_seq #(.SEL_W(3), .NUM_OUT(6), .SCAN_DIV(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .y(ya), .y_valid(yva), .err(erra)
  );

  decoder_nto1hot_seq #(.SEL_W(3), .NUM_OUT(8), .SCAN_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .y(yb), .y_valid(yvb), .err(errb)
  );

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  int n_out[2]  = '{6, 8};
  int s_div[2]  = '{3, 1};
  int m_idx[2];
  int m_dwell[2];
  int m_y[2];
  int m_err[2];
  bit m_in_scan[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_dwell[k] = 0; m_y[k] = 0; m_err[k] = 0; m_in_scan[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0;
      if (!en) begin
        m_y[k] = 0;
        m_dwell[k] = 0;
        m_in_scan[k] = 1'b0;
      end else if (mode == 2'b10) begin
        if (!m_in_scan[k]) m_dwell[k] = 0;
        m_in_scan[k] = 1'b1;
        m_y[k] = 1 << m_idx[k];
        m_dwell[k]++;
        if (m_dwell[k] == s_div[k]) begin
          m_dwell[k] = 0;
          m_idx[k] = (m_idx[k] + 1) % n_out[k];
        end
      end else begin
        m_in_scan[k] = 1'b0;
        if (sel_valid) begin
          if (int'(sel) >= n_out[k]) begin
            m_y[k] = 0;
            m_err[k] = 1;
          end else begin
            m_idx[k] = int'(sel);
            m_y[k] = 1 << int'(sel);
          end
        end else if (mode == 2'b01) begin
          m_y[k] = 0;
        end
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".ya"},   32'(ya),   m_y[0]);
    chk({tag, ".yva"},  32'(yva),  (m_y[0] != 0) ? 1 : 0);
    chk({tag, ".erra"}, 32'(erra), m_err[0]);
    chk({tag, ".yb"},   32'(yb),   m_y[1]);
    chk({tag, ".yvb"},  32'(yvb),  (m_y[1] != 0) ? 1 : 0);
    chk({tag, ".errb"}, 32'(errb), m_err[1]);
  endtask

  // Inputs change only at negedge; the model consumes them at posedge, outputs are compared at negedge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    cmp_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, ".imm_ya"}, 32'(ya), 0);
    chk({tag, ".imm_yb"}, 32'(yb), 0);
    chk({tag, ".imm_err"}, 32'({erra, errb, yva, yvb}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel_valid = 1'b0; sel = '0;
    model_reset();
    #1;
    chk("reset.ya", 32'(ya), 0);
    chk("reset.yb", 32'(yb), 0);
    chk("reset.flags", 32'({yva, erra, yvb, errb}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Level mode: sel=5 holds, then en=0 clears.
    en = 1'b1; mode = 2'b00; sel_valid = 1'b1; sel = 3'd5;
    tick("lvl_acc");
    chk("lvl_y5", 32'(yb), 32'h20);
    sel_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick("lvl_hold");
      chk("lvl_hold_y", 32'(yb), 32'h20);
      chk("lvl_hold_v", 32'(yvb), 1);
    end
    en = 1'b0;
    tick("lvl_off");
    chk("lvl_off_y", 32'(yb), 0);

    // Pulse mode: sel 0,1,7 back-to-back.
    en = 1'b1; mode = 2'b01; sel_valid = 1'b1;
    sel = 3'd0; tick("pls0"); chk("pls0_y", 32'(yb), 32'h01);
    sel = 3'd1; tick("pls1"); chk("pls1_y", 32'(yb), 32'h02);
    sel = 3'd7; tick("pls7"); chk("pls7_y", 32'(yb), 32'h80); chk("pls7_erra", 32'(erra), 1);
    sel_valid = 1'b0; tick("pls_end"); chk("pls_end_y", 32'(yb), 0); chk("pls_errb", 32'(errb), 0);

    // Out-of-range on the 6-output instance, then a legal select.
    mode = 2'b00; sel_valid = 1'b1; sel = 3'd6;
    tick("oor"); chk("oor_err", 32'(erra), 1); chk("oor_y", 32'(ya), 0);
    sel_valid = 1'b0; tick("oor_clr"); chk("oor_err_clr", 32'(erra), 0);
    sel_valid = 1'b1; sel = 3'd2;
    tick("oor_next"); chk("oor_next_y", 32'(ya), 32'h04);

    // Scan from idx=2, stray sel_valid pulses ignored.
    mode = 2'b10;
    for (int i = 0; i < 18; i++) begin
      sel_valid = 1'($urandom_range(0, 1)); sel = 3'($urandom_range(0, 7));
      tick("scan");
      chk("scan_ya", 32'(ya), 1 << ((2 + i / 3) % 6));
      chk("scan_yb", 32'(yb), 1 << ((2 + i) % 8));
    end
    sel_valid = 1'b0;
    tick("scan_mid");
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick("scan_off");
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("scan_resume");
      chk("scan_resume_ya", 32'(ya), 32'h04);
    end
    tick("scan_adv");
    chk("scan_adv_ya", 32'(ya), 32'h08);

    // Asynchronous reset mid-scan, then a level accept of sel=3.
    async_reset("rst_scan");
    mode = 2'b00; sel_valid = 1'b1; sel = 3'd3;
    tick("post_rst");
    chk("post_rst_yb", 32'(yb), 32'h08);
    sel_valid = 1'b0;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      sel_valid = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
